// File: rtl/dn_rom_sched.sv
// rtl/dn_rom_sched.sv - ROM download sequencer: region decode, graphics write FIFO, core reset hold
// Graphics bytes queue behind video fetches; core reset is released RST_HOLD cycles after the queue drains.
module dn_rom_sched #(
    parameter int FIFO_DEPTH = 4,
    parameter int RST_HOLD   = 16
) (
    input  logic        clock_12,
    input  logic        reset,
    input  logic        dn_active,
    input  logic        dn_wr,
    input  logic [17:0] dn_addr,
    input  logic [7:0]  dn_data,
    input  logic        vid_req,
    output logic        wr_en,
    output logic [1:0]  wr_region,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        gfx_we,
    output logic [15:0] gfx_addr,
    output logic [7:0]  gfx_data,
    output logic        core_reset,
    output logic        dn_overflow,
    output logic        dn_done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [7:0] HOLD_INIT = 8'(RST_HOLD - 1);
    localparam logic [1:0] REGION_GFX = 2'd2;

    typedef enum logic [1:0] {
        S_HOLD,
        S_RUN,
        S_LOAD,
        S_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          done_d;
    logic [AW:0]   wp_q, rp_q;
    logic [23:0]   mem_q [FIFO_DEPTH];
    logic          wr_en_q;
    logic [1:0]    wr_region_q;
    logic [15:0]   wr_addr_q;
    logic [7:0]    wr_data_q;

    logic [1:0]    region;
    logic          in_load;
    logic          in_drain;
    logic          accept;
    logic          gfx_byte;
    logic          direct_byte;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          push;
    logic          drop;
    logic [23:0]   head;

    assign region      = dn_addr[17:16];
    assign in_load     = (state_q == S_LOAD);
    assign in_drain    = (state_q == S_DRAIN);
    assign accept      = in_load & dn_wr;
    assign gfx_byte    = accept & (region == REGION_GFX);
    assign direct_byte = accept & (region != REGION_GFX);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty  = (wp_q == rp_q);
    assign fifo_full   = ((wp_q ^ rp_q) == {1'b1, {AW{1'b0}}});

    // Video always owns the RAM when it asks; the queue simply waits.
    assign pop         = ~fifo_empty & ~vid_req & (in_load | in_drain);
    assign push        = gfx_byte & (~fifo_full | pop);
    assign drop        = gfx_byte & fifo_full & ~pop;

    assign head        = mem_q[rp_q[AW-1:0]];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q | drop;
        done_d  = 1'b0;
        case (state_q)
            S_HOLD: begin
                if (dn_active) begin
                    state_d = S_LOAD;
                    ovf_d   = 1'b0;
                end else if (cnt_q == 8'd0) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_RUN: begin
                if (dn_active) begin
                    state_d = S_LOAD;
                    ovf_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (!dn_active) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (dn_active) begin
                    state_d = S_LOAD;
                end else if (fifo_empty && !pop) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_INIT;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_HOLD;
                cnt_d   = HOLD_INIT;
            end
        endcase
    end

    always_ff @(posedge clock_12 or posedge reset) begin
        if (reset) begin
            state_q     <= S_HOLD;
            cnt_q       <= HOLD_INIT;
            ovf_q       <= 1'b0;
            wp_q        <= '0;
            rp_q        <= '0;
            wr_en_q     <= 1'b0;
            wr_region_q <= 2'd0;
            wr_addr_q   <= 16'd0;
            wr_data_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            wr_en_q <= direct_byte;
            if (push) begin
                wp_q <= wp_q + (AW+1)'(1);
            end
            if (pop) begin
                rp_q <= rp_q + (AW+1)'(1);
            end
            if (direct_byte) begin
                wr_region_q <= region;
                wr_addr_q   <= dn_addr[15:0];
                wr_data_q   <= dn_data;
            end
        end
    end

    always_ff @(posedge clock_12) begin
        if (push) begin
            mem_q[wp_q[AW-1:0]] <= {dn_addr[15:0], dn_data};
        end
    end

    // A download request holds the core in reset in the very cycle it is seen.
    assign core_reset  = (state_q != S_RUN) | (state_d == S_LOAD);
    assign wr_en       = wr_en_q;
    assign wr_region   = wr_region_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign gfx_we      = pop;
    assign gfx_addr    = head[23:8];
    assign gfx_data    = head[7:0];
    assign dn_overflow = ovf_q;
    assign dn_done     = done_d;

endmodule

// File: tb/tb_dn_rom_sched.sv
// tb/tb_dn_rom_sched.sv - self-checking bench for dn_rom_sched
module tb_dn_rom_sched;

    localparam int DEPTH = 4;
    localparam int HOLD  = 16;
    localparam int M_HOLD = 0, M_RUN = 1, M_LOAD = 2, M_DRAIN = 3;

    logic        clock_12 = 1'b0;
    logic        reset = 1'b1;
    logic        dn_active = 1'b0;
    logic        dn_wr = 1'b0;
    logic [17:0] dn_addr = '0;
    logic [7:0]  dn_data = '0;
    logic        vid_req = 1'b0;
    logic        wr_en;
    logic [1:0]  wr_region;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        gfx_we;
    logic [15:0] gfx_addr;
    logic [7:0]  gfx_data;
    logic        core_reset;
    logic        dn_overflow;
    logic        dn_done;

    always #5 clock_12 = ~clock_12;

    dn_rom_sched #(.FIFO_DEPTH(DEPTH), .RST_HOLD(HOLD)) dut (
        .clock_12(clock_12), .reset(reset), .dn_active(dn_active), .dn_wr(dn_wr),
        .dn_addr(dn_addr), .dn_data(dn_data), .vid_req(vid_req),
        .wr_en(wr_en), .wr_region(wr_region), .wr_addr(wr_addr), .wr_data(wr_data),
        .gfx_we(gfx_we), .gfx_addr(gfx_addr), .gfx_data(gfx_data),
        .core_reset(core_reset), .dn_overflow(dn_overflow), .dn_done(dn_done)
    );

    int vec = 0;
    int errs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: mode, countdown, pending queue, last direct write.
    typedef struct { logic [15:0] a; logic [7:0] d; } ent_t;
    int          m_mode;
    int          m_cnt;
    bit          m_ovf;
    ent_t        m_q[$];
    bit          m_wen;
    logic [1:0]  m_rgn;
    logic [15:0] m_wa;
    logic [7:0]  m_wd;
    bit          e_pop;

    task automatic model_reset();
        m_mode = M_HOLD;
        m_cnt  = HOLD - 1;
        m_ovf  = 1'b0;
        m_q.delete();
        m_wen  = 1'b0;
        m_rgn  = 2'd0;
        m_wa   = 16'd0;
        m_wd   = 8'd0;
    endtask

    task automatic model_check();
        bit e_crst, e_done;
        e_crst = !(m_mode == M_RUN && !dn_active);
        e_pop  = (m_q.size() != 0) && !vid_req && (m_mode == M_LOAD || m_mode == M_DRAIN);
        e_done = (m_mode == M_DRAIN) && !dn_active && (m_q.size() == 0);
        chk("core_reset", 32'(core_reset), 32'(e_crst));
        chk("wr_en", 32'(wr_en), 32'(m_wen));
        if (m_wen) begin
            chk("wr_region", 32'(wr_region), 32'(m_rgn));
            chk("wr_addr", 32'(wr_addr), 32'(m_wa));
            chk("wr_data", 32'(wr_data), 32'(m_wd));
        end
        chk("gfx_we", 32'(gfx_we), 32'(e_pop));
        if (e_pop) begin
            chk("gfx_addr", 32'(gfx_addr), 32'(m_q[0].a));
            chk("gfx_data", 32'(gfx_data), 32'(m_q[0].d));
        end
        chk("dn_overflow", 32'(dn_overflow), 32'(m_ovf));
        chk("dn_done", 32'(dn_done), 32'(e_done));
    endtask

    task automatic model_advance();
        bit   acc;
        int   sz;
        ent_t e;
        acc = (m_mode == M_LOAD) && dn_wr;
        sz  = m_q.size();
        m_wen = acc && (dn_addr[17:16] != 2'd2);
        if (m_wen) begin
            m_rgn = dn_addr[17:16];
            m_wa  = dn_addr[15:0];
            m_wd  = dn_data;
        end
        if (e_pop) m_q.delete(0);
        if (acc && dn_addr[17:16] == 2'd2) begin
            if (sz < DEPTH || e_pop) begin
                e.a = dn_addr[15:0];
                e.d = dn_data;
                m_q.push_back(e);
            end else begin
                m_ovf = 1'b1;
            end
        end
        case (m_mode)
            M_HOLD:  if (dn_active) begin m_mode = M_LOAD; m_ovf = 1'b0; end
                     else if (m_cnt == 0) m_mode = M_RUN;
                     else m_cnt--;
            M_RUN:   if (dn_active) begin m_mode = M_LOAD; m_ovf = 1'b0; end
            M_LOAD:  if (!dn_active) m_mode = M_DRAIN;
            default: if (dn_active) m_mode = M_LOAD;
                     else if (sz == 0) begin m_mode = M_HOLD; m_cnt = HOLD - 1; end
        endcase
    endtask

    task automatic apply(input bit act, input bit wr, input logic [17:0] a, input logic [7:0] d, input bit vid);
        @(negedge clock_12);
        dn_active = act;
        dn_wr     = wr;
        dn_addr   = a;
        dn_data   = d;
        vid_req   = vid;
        #1;
        model_check();
    endtask

    task automatic tick();
        @(posedge clock_12);
        model_advance();
    endtask

    typedef struct {
        bit act; bit wr; logic [17:0] addr; logic [7:0] data; bit vid;
        bit crst; bit wen; logic [1:0] rgn; logic [15:0] wa; logic [7:0] wd;
        bit gwe; logic [15:0] ga; logic [7:0] gd; bit ovf; bit done;
    } row_t;

    task automatic check_reset_values(input string tag);
        chk({tag, "_core_reset"}, 32'(core_reset), 32'd1);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_gfx_we"}, 32'(gfx_we), 32'd0);
        chk({tag, "_overflow"}, 32'(dn_overflow), 32'd0);
        chk({tag, "_done"}, 32'(dn_done), 32'd0);
        chk({tag, "_wr_region"}, 32'(wr_region), 32'd0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time %0t exceeded limit 1000000", $time);
        $fatal(1);
    end

    initial begin
        row_t tbl[14];
        int   ones, strobes, nw, nd, after, gwe_cnt;
        bit   seen, fell, ract;

        tbl[0]  = '{1'b1, 1'b0, 18'h00000, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 18'h01234, 8'hA5, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 18'h3000F, 8'h5A, 1'b0, 1'b1, 1'b1, 2'd0, 16'h1234, 8'hA5, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 18'h10077, 8'h3C, 1'b0, 1'b1, 1'b1, 2'd3, 16'h000F, 8'h5A, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 18'h20000, 8'h10, 1'b1, 1'b1, 1'b1, 2'd1, 16'h0077, 8'h3C, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 18'h20001, 8'h11, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 18'h20002, 8'h12, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 18'h00000, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 18'h00000, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b1, 16'h0000, 8'h10, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 18'h00000, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b1, 16'h0001, 8'h11, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 18'h00000, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b1, 16'h0002, 8'h12, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 18'h20055, 8'h77, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 18'h00000, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b1, 16'h0055, 8'h77, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 18'h00000, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0};

        model_reset();
        repeat (3) @(posedge clock_12);
        @(negedge clock_12);
        #1;
        check_reset_values("por");
        @(posedge clock_12);
        #2 reset = 1'b0;
        model_reset();

        // Idle after reset: strobes on dn_wr must be ignored outside LOAD.
        ones = 0;
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            apply(1'b0, 1'b1, 18'(i), 8'(i), 1'b0);
            if (core_reset) ones++;
            if (wr_en || gfx_we || dn_done) strobes++;
            tick();
        end
        chk("release_hold_cycles", 32'(ones), 32'd16);
        chk("release_no_strobes", 32'(strobes), 32'd0);

        for (int i = 0; i < 14; i++) begin
            apply(tbl[i].act, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].vid);
            chk($sformatf("tbl%0d_core_reset", i), 32'(core_reset), 32'(tbl[i].crst));
            chk($sformatf("tbl%0d_wr_en", i), 32'(wr_en), 32'(tbl[i].wen));
            if (tbl[i].wen) begin
                chk($sformatf("tbl%0d_wr_region", i), 32'(wr_region), 32'(tbl[i].rgn));
                chk($sformatf("tbl%0d_wr_addr", i), 32'(wr_addr), 32'(tbl[i].wa));
                chk($sformatf("tbl%0d_wr_data", i), 32'(wr_data), 32'(tbl[i].wd));
            end
            chk($sformatf("tbl%0d_gfx_we", i), 32'(gfx_we), 32'(tbl[i].gwe));
            if (tbl[i].gwe) begin
                chk($sformatf("tbl%0d_gfx_addr", i), 32'(gfx_addr), 32'(tbl[i].ga));
                chk($sformatf("tbl%0d_gfx_data", i), 32'(gfx_data), 32'(tbl[i].gd));
            end
            chk($sformatf("tbl%0d_overflow", i), 32'(dn_overflow), 32'(tbl[i].ovf));
            chk($sformatf("tbl%0d_done", i), 32'(dn_done), 32'(tbl[i].done));
            tick();
        end

        // Overflow: five bytes against a four-entry queue while video holds the RAM.
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 1'b1, 18'h20100 + 18'(i), 8'hC0 + 8'(i), 1'b1);
            tick();
        end
        apply(1'b1, 1'b0, 18'h0, 8'h0, 1'b1);
        chk("ovf_set", 32'(dn_overflow), 32'd1);
        tick();
        nw = 0;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 1'b0, 18'h0, 8'h0, 1'b0);
            if (gfx_we) begin
                chk($sformatf("ovf_drain_addr%0d", nw), 32'(gfx_addr), 32'h0100 + 32'(nw));
                chk($sformatf("ovf_drain_data%0d", nw), 32'(gfx_data), 32'hC0 + 32'(nw));
                nw++;
            end
            if (dn_done) nd++;
            tick();
        end
        chk("ovf_drain_writes", 32'(nw), 32'd4);
        chk("ovf_drain_done", 32'(nd), 32'd1);
        apply(1'b1, 1'b0, 18'h0, 8'h0, 1'b0);
        chk("ovf_held_until_load", 32'(dn_overflow), 32'd1);
        tick();
        apply(1'b1, 1'b0, 18'h0, 8'h0, 1'b0);
        chk("ovf_cleared_on_load", 32'(dn_overflow), 32'd0);
        tick();

        // Drain before release: two bytes pending while video blocks.
        apply(1'b1, 1'b1, 18'h20200, 8'hD0, 1'b1);
        tick();
        apply(1'b1, 1'b1, 18'h20201, 8'hD1, 1'b1);
        tick();
        for (int i = 0; i < 6; i++) begin
            apply(1'b0, 1'b0, 18'h0, 8'h0, 1'b1);
            chk("drain_blocked_core_reset", 32'(core_reset), 32'd1);
            chk("drain_blocked_done", 32'(dn_done), 32'd0);
            tick();
        end
        nw = 0;
        nd = 0;
        after = 0;
        seen = 1'b0;
        fell = 1'b0;
        for (int i = 0; i < 30; i++) begin
            apply(1'b0, 1'b0, 18'h0, 8'h0, 1'b0);
            if (gfx_we) begin
                chk($sformatf("drain_addr%0d", nw), 32'(gfx_addr), 32'h0200 + 32'(nw));
                nw++;
            end
            if (dn_done) begin
                nd++;
                seen = 1'b1;
            end else if (seen && !fell) begin
                if (core_reset) after++;
                else fell = 1'b1;
            end
            tick();
        end
        chk("drain_writes", 32'(nw), 32'd2);
        chk("drain_done_pulses", 32'(nd), 32'd1);
        chk("drain_release_delay", 32'(after), 32'd16);
        chk("drain_core_released", 32'(fell), 32'd1);

        // Asynchronous reset while three entries wait in DRAIN.
        apply(1'b1, 1'b0, 18'h0, 8'h0, 1'b0);
        tick();
        apply(1'b1, 1'b1, 18'h1ABCD, 8'hEE, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b1, 18'h20300 + 18'(i), 8'hE0 + 8'(i), 1'b1);
            tick();
        end
        apply(1'b0, 1'b0, 18'h0, 8'h0, 1'b1);
        tick();
        apply(1'b0, 1'b0, 18'h0, 8'h0, 1'b1);
        tick();
        @(negedge clock_12);
        vid_req = 1'b0;
        #2 reset = 1'b1;
        #1;
        check_reset_values("async");
        model_reset();
        @(posedge clock_12);
        #2 reset = 1'b0;
        gwe_cnt = 0;
        ones = 0;
        for (int i = 0; i < 20; i++) begin
            apply(1'b0, 1'b0, 18'h0, 8'h0, 1'b0);
            if (gfx_we) gwe_cnt++;
            if (core_reset) ones++;
            tick();
        end
        chk("async_no_gfx_we", 32'(gwe_cnt), 32'd0);
        chk("async_hold_cycles", 32'(ones), 32'd16);

        ract = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39) == 0) ract = !ract;
            apply(ract, 1'($urandom_range(1)), 18'($urandom), 8'($urandom), ($urandom_range(9) < 4));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/dn_rom_sched.md
# dn_rom_sched

Download sequencer and arbiter between the HPS ROM download stream and the Williams-2 core's memories. It holds the core in reset while ROM images load and decodes each download byte into a target region. Graphics-ROM bytes are posted through a small FIFO so they never collide with video fetches on the single-port graphics RAM. It releases core reset a fixed number of cycles after the last byte is committed. It sits between hps_io's ioctl outputs and williams2's memory write ports.

## Interface
Parameters:
- FIFO_DEPTH, 4, number of graphics write entries; must be a power of two, 2..16.
- RST_HOLD, 16, number of clock_12 cycles that core_reset stays high after the FIFO drains; 1..255.

Ports:
- clock_12  in  1  system clock, 12 MHz.
- reset  in  1  asynchronous, active-high.
- dn_active  in  1  download in progress (ioctl_download, index 0 only).
- dn_wr  in  1  one-cycle byte strobe.
- dn_addr  in  18  download byte address.
- dn_data  in  8  download byte.
- vid_req  in  1  video owns the graphics RAM this cycle.
- wr_en  out  1  direct write strobe for program, sound and PROM regions.
- wr_region  out  2  region select: 0=program, 1=sound, 3=PROM.
- wr_addr  out  16  address within the region (dn_addr[15:0]).
- wr_data  out  8  byte to write.
- gfx_we  out  1  graphics RAM write strobe.
- gfx_addr  out  16  graphics RAM address.
- gfx_data  out  8  graphics RAM byte.
- core_reset  out  1  reset for williams2.
- dn_overflow  out  1  sticky: a graphics byte was dropped.
- dn_done  out  1  one-cycle pulse when a download is fully committed.

## Operation
- Region is dn_addr[17:16]: 0 = program, 1 = sound, 2 = graphics, 3 = PROM.
- FSM states:
  - HOLD: counting down; core_reset=1. Counter reaches 0 → RUN. dn_active=1 → LOAD (counter abandoned).
  - RUN: core_reset=0. dn_active=1 → LOAD.
  - LOAD: core_reset=1; accepts dn_wr. dn_active=0 → DRAIN.
  - DRAIN: core_reset=1; dn_wr ignored. dn_active=1 → LOAD, FIFO contents kept. FIFO empty and no pop this cycle → HOLD, with dn_done pulsed on that transition.
- Entering HOLD loads the counter with RST_HOLD−1. The counter decrements each cycle in HOLD.
- Every entry into LOAD from HOLD or RUN clears dn_overflow.
- dn_wr is ignored in every state except LOAD.
- In LOAD, dn_wr to region 0, 1 or 3: wr_en=1 on the next cycle, with wr_region, wr_addr and wr_data registered from the strobe cycle. wr_en is otherwise 0.
- In LOAD, dn_wr to region 2: push {dn_addr[15:0], dn_data} into the FIFO.
  - FIFO full with no pop in the same cycle: the byte is dropped and dn_overflow is set.
  - Push and pop in the same cycle while full: the push is accepted.
- Pop/drain rule:
  - gfx_we = FIFO not empty AND vid_req=0 AND state in {LOAD, DRAIN}.
  - gfx_addr and gfx_data come combinationally from the FIFO head.
  - The head pops on the clock edge where gfx_we=1.
  - Video always wins the graphics RAM; there is no starvation timeout.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2·FIFO_DEPTH.
  - full: pointers differ only in the MSB.
  - empty: pointers are equal.

## Timing
- Reset values:
  - State HOLD, counter RST_HOLD−1, FIFO empty.
  - core_reset=1.
  - wr_en, gfx_we, dn_overflow and dn_done all 0.
  - wr_region, wr_addr, wr_data all 0.
- Reset asserted mid-download discards the FIFO contents and returns to HOLD. The download restarts only on the next LOAD.
- Latency:
  - Direct regions: exactly 1 cycle from dn_wr to wr_en.
  - Graphics: the earliest gfx_we is 1 cycle after the push, i.e. the first cycle after the push edge with vid_req=0.
- dn_active sampled 1 → core_reset is already 1 in that same cycle (combinational from the LOAD transition) and stays 1 thereafter until leaving HOLD.
- After dn_active falls with an empty FIFO:
  - DRAIN lasts 1 cycle.
  - HOLD lasts RST_HOLD cycles.
  - core_reset falls RST_HOLD+1 cycles after dn_active falls.
- dn_done is high for exactly the one cycle of the DRAIN→HOLD transition.

## Test plan
- Reset release, dn_active=0: core_reset stays 1 for exactly 16 cycles, then 0. No write strobes and no dn_done.
- Region routing in LOAD:
  - dn_wr at addr 18'h01234 with data 8'hA5 → next cycle wr_en=1, wr_region=0, wr_addr=16'h1234, wr_data=8'hA5.
  - addr 18'h3000F → wr_region=3.
- Graphics under contention:
  - vid_req=1 held while 3 bytes go to 18'h20000..20002 → gfx_we stays 0.
  - vid_req then dropped → gfx_we=1 for 3 consecutive cycles, addresses 0,1,2 in order with matching data.
- Overflow: vid_req=1 with 5 graphics bytes pushed → the 5th is dropped and dn_overflow=1. After drain, the 4 stored bytes are written. dn_overflow clears on the next download start.
- Drain before release: 2 graphics bytes pending, vid_req=1, dn_active falls →
  - state stays in DRAIN with core_reset=1;
  - after vid_req drops, the 2 writes occur, dn_done pulses once, then core_reset falls 16 cycles later.
- Async reset mid-drain with 3 entries queued → outputs return to reset values immediately. No gfx_we after release; HOLD restarts.
